lfsr_param: RTL and testbench
=============================

// Module: lfsr_param
// PURPOSE
//  Parametrised pseudo-random sequence generator: WIDTH-bit LFSR, Galois or Fibonacci form,
//  with runtime seed load, step enable, zero-state lockup recovery and period measurement.
//  Next-generation replacement for the fixed 6-bit generator; feeds test-pattern and scrambler paths.
// PARAMETERS
//  WIDTH  6             register width, 3..32
//  TAPS   6'b100001     polynomial mask: bit k = coeff of x^k (x^WIDTH implicit); TAPS[0] must be 1
//  SEED   6'b111111     reset / recovery state, must be non-zero
//  MODE   0             0 = Galois (internal XOR), 1 = Fibonacci (external XOR)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      async active-low reset
//  en          in   1      advance one step this cycle
//  load        in   1      load seed_in this cycle (priority over en)
//  seed_in     in   WIDTH  runtime seed
//  q           out  WIDTH  current LFSR state
//  serial_out  out  1      q[WIDTH-1]
//  period_done out  1      1-cycle pulse: state returned to start state
//  period_len  out  WIDTH  steps of last completed period
//  seed_err    out  1      1-cycle pulse: zero seed rejected, or zero state recovered
// BEHAVIOUR
//  - rst=0 (async, any time): q=SEED, start=SEED, cnt=0, period_done=0, period_len=0, seed_err=0.
//  - All outputs registered; state change visible one cycle after the qualifying edge.
//  - Per-edge priority: load > zero-state recovery > en > hold.
//  - load: seed_in!=0 -> q=seed_in, start=seed_in, cnt=0. seed_in==0 -> q=SEED, start=SEED,
//    cnt=0, seed_err=1. period_len unchanged by load.
//  - q==0 with en=1 (unreachable unless forced): q=SEED, start=SEED, cnt=0, seed_err=1.
//  - en=1, Galois: n[0]=q[W-1]; n[k]=q[k-1] ^ (TAPS[k] & q[W-1]), k=1..W-1.
//  - en=1, Fibonacci: n={q[W-2:0], fb}, fb=^(q & bitrev(TAPS)).
//  - en=0, load=0: q, cnt, start held; period_done=0.
//  - Step counter cnt (WIDTH bits): +1 per step. If next state == start: period_done=1,
//    period_len=cnt+1, cnt=0. Cannot overflow: period <= 2^WIDTH-1.
//  - period_done / seed_err are never high without a step/load/recovery in the same cycle.
//  - Primitive TAPS => period 2^WIDTH-1 in both modes; non-primitive TAPS legal, shorter period.
// STRUCTURE
//  - lfsr_pkg: MODE_GALOIS=0 / MODE_FIBONACCI=1 constants, bitrev function, default primitive
//    masks per width (6:'b100001, 8:'b00011101, 16:'h002D).
//  - Sub-module lfsr_cell: 1-bit flop, async active-low preset/clear, selected per bit from SEED;
//    instantiated WIDTH times in generate loop. Next-state, counter, compare logic in lfsr_param.
// TESTING  (W=6, TAPS=6'b100001, SEED=6'b111111 unless noted)
//  1. rst low 25 ns then high, en=1, MODE=0 -> q: 111111, 011111, 111110, ...; seed_err=0.
//  2. MODE=1, same stimulus -> q: 111111, 111110, 111101, ...
//  3. en=1 for 63 cycles after reset -> period_done pulses on step 63 only, period_len=63,
//     q back to 111111; 63 distinct non-zero states in between.
//  4. load=1, seed_in=000000 -> q=111111, seed_err=1 one cycle; load=1, seed_in=000101 with
//     en=1 same cycle -> q=000101 (load wins), period_len unchanged.
//  5. en toggled 1,0,0,1 -> q holds during en=0; cnt held; period still 63 counted steps.
//  6. rst asserted mid-cycle mid-sequence -> q=111111 immediately (no clock), cnt=0,
//     period_len=0; force q=0 with en=1 -> q=SEED next edge, seed_err=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR: mode codes,
// bit reversal for Fibonacci tap masks and default primitive polynomials.
package lfsr_pkg;

  localparam int MODE_GALOIS    = 0;
  localparam int MODE_FIBONACCI = 1;

  localparam logic [31:0] TAPS_W6  = 32'h0000_0021;
  localparam logic [31:0] TAPS_W8  = 32'h0000_001D;
  localparam logic [31:0] TAPS_W16 = 32'h0000_002D;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_LOAD    = 2'd1,
    ACT_RECOVER = 2'd2,
    ACT_STEP    = 2'd3
  } lfsr_act_e;

  // Reverse the low w bits of v; bits at and above w are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        r[i] = v[w - 1 - i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] default_taps(input int unsigned w);
    case (w)
      6:       return TAPS_W6;
      8:       return TAPS_W8;
      16:      return TAPS_W16;
      default: return TAPS_W6;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_cell.sv
// One state bit of the LFSR: a D flop whose asynchronous reset either
// presets or clears it, chosen at elaboration from the seed bit.
module lfsr_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // State bit with reset value taken from the seed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/lfsr_param.sv
// WIDTH-bit Galois/Fibonacci LFSR with seed load, step enable, zero-state
// recovery and measurement of the number of steps per period.
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W6),
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               MODE  = MODE_GALOIS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  localparam logic [WIDTH-1:0] TAPS_REV = WIDTH'(bitrev(32'(TAPS), WIDTH));
  // The x^0 coefficient is realised by the feedback wire into bit 0 itself.
  localparam logic [WIDTH-1:0] TAPS_GAL = TAPS & ~WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_len_q, period_len_d;
  logic             period_done_q, period_done_d;
  logic             seed_err_q, seed_err_d;
  logic [WIDTH-1:0] gal_s, fib_s, step_s;
  lfsr_act_e        act_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    lfsr_cell #(.RST_VAL(SEED[i])) u_cell (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (state_d[i]),
      .q_o    (cell_q[i])
    );
  end

  assign state_q = cell_q;

  assign gal_s  = {state_q[WIDTH-2:0], state_q[WIDTH-1]} ^ (TAPS_GAL & {WIDTH{state_q[WIDTH-1]}});
  assign fib_s  = {state_q[WIDTH-2:0], ^(state_q & TAPS_REV)};
  assign step_s = (MODE == MODE_FIBONACCI) ? fib_s : gal_s;

  // Per-edge action select: load beats zero recovery beats step.
  always_comb begin
    act_s = ACT_HOLD;
    if (load) begin
      act_s = ACT_LOAD;
    end else if (en && (state_q == '0)) begin
      act_s = ACT_RECOVER;
    end else if (en) begin
      act_s = ACT_STEP;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next state, start marker, step counter and status pulses.
  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    cnt_d         = cnt_q;
    period_len_d  = period_len_q;
    period_done_d = 1'b0;
    seed_err_d    = 1'b0;
    case (act_s)
      ACT_LOAD: begin
        cnt_d = '0;
        if (seed_in != '0) begin
          state_d = seed_in;
          start_d = seed_in;
        end else begin
          state_d    = SEED;
          start_d    = SEED;
          seed_err_d = 1'b1;
        end
      end
      ACT_RECOVER: begin
        state_d    = SEED;
        start_d    = SEED;
        cnt_d      = '0;
        seed_err_d = 1'b1;
      end
      ACT_STEP: begin
        state_d = step_s;
        if (step_s == start_q) begin
          period_done_d = 1'b1;
          period_len_d  = cnt_q + ONE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ACT_HOLD: begin
        state_d = state_q;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Bookkeeping and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q       <= SEED;
      cnt_q         <= '0;
      period_len_q  <= '0;
      period_done_q <= 1'b0;
      seed_err_q    <= 1'b0;
    end else begin
      start_q       <= start_d;
      cnt_q         <= cnt_d;
      period_len_q  <= period_len_d;
      period_done_q <= period_done_d;
      seed_err_q    <= seed_err_d;
    end
  end

  assign q           = state_q;
  assign serial_out  = state_q[WIDTH-1];
  assign period_done = period_done_q;
  assign period_len  = period_len_q;
  assign seed_err    = seed_err_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Bench for lfsr_param: Galois and Fibonacci instances driven in lockstep,
// checked against a polynomial-arithmetic reference model.
module tb_lfsr_param;

  localparam logic [5:0] TAPS = 6'b100001;
  localparam logic [5:0] SEED = 6'b111111;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [5:0] seed_in;
  logic [5:0] q_g, q_f, len_g, len_f;
  logic       so_g, so_f, done_g, done_f, err_g, err_f;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] mq[2];
  logic [5:0] mstart[2];
  logic [5:0] mlen[2];
  int         mcnt[2];
  logic       mdone[2];
  logic       merr[2];

  always #5 clk = ~clk;

  lfsr_param #(.WIDTH(6), .TAPS(TAPS), .SEED(SEED), .MODE(0)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .q(q_g), .serial_out(so_g), .period_done(done_g), .period_len(len_g), .seed_err(err_g)
  );

  lfsr_param #(.WIDTH(6), .TAPS(TAPS), .SEED(SEED), .MODE(1)) u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .q(q_f), .serial_out(so_f), .period_done(done_f), .period_len(len_f), .seed_err(err_f)
  );

  // Galois step = multiply the state polynomial by x modulo p(x).
  function automatic logic [5:0] gal_next(input logic [5:0] v);
    logic [6:0] t;
    t = {v, 1'b0};
    if (t[6]) t = t ^ {1'b1, TAPS};
    return t[5:0];
  endfunction

  // Fibonacci step: feedback is the XOR of bits selected by the mirrored taps.
  function automatic logic [5:0] fib_next(input logic [5:0] v);
    logic       fb;
    logic [5:0] tp;
    tp = TAPS;
    fb = 1'b0;
    for (int k = 0; k < 6; k++) if (tp[k]) fb = fb ^ v[5 - k];
    return {v[4:0], fb};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m] = SEED; mstart[m] = SEED; mlen[m] = 6'd0;
      mcnt[m] = 0; mdone[m] = 1'b0; merr[m] = 1'b0;
    end
  endtask

  task automatic model_update(input logic e, input logic l, input logic [5:0] s);
    logic [5:0] nq;
    for (int m = 0; m < 2; m++) begin
      mdone[m] = 1'b0;
      merr[m]  = 1'b0;
      if (l) begin
        mcnt[m] = 0;
        if (s != 6'd0) begin
          mq[m] = s; mstart[m] = s;
        end else begin
          mq[m] = SEED; mstart[m] = SEED; merr[m] = 1'b1;
        end
      end else if (e && mq[m] == 6'd0) begin
        mq[m] = SEED; mstart[m] = SEED; mcnt[m] = 0; merr[m] = 1'b1;
      end else if (e) begin
        nq = (m == 0) ? gal_next(mq[m]) : fib_next(mq[m]);
        mq[m] = nq;
        mcnt[m] = mcnt[m] + 1;
        if (nq == mstart[m]) begin
          mdone[m] = 1'b1; mlen[m] = 6'(mcnt[m]); mcnt[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_gal_q"},    32'(q_g),    32'(mq[0]));
    chk({tag, "_fib_q"},    32'(q_f),    32'(mq[1]));
    chk({tag, "_gal_so"},   32'(so_g),   32'(mq[0][5]));
    chk({tag, "_fib_so"},   32'(so_f),   32'(mq[1][5]));
    chk({tag, "_gal_done"}, 32'(done_g), 32'(mdone[0]));
    chk({tag, "_fib_done"}, 32'(done_f), 32'(mdone[1]));
    chk({tag, "_gal_len"},  32'(len_g),  32'(mlen[0]));
    chk({tag, "_fib_len"},  32'(len_f),  32'(mlen[1]));
    chk({tag, "_gal_err"},  32'(err_g),  32'(merr[0]));
    chk({tag, "_fib_err"},  32'(err_f),  32'(merr[1]));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input logic e, input logic l, input logic [5:0] s);
    en = e; load = l; seed_in = s;
    @(posedge clk);
    model_update(e, l, s);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    bit   seen[64];
    int   distinct;
    int   pulses;
    int   steps;
    logic e, l;
    logic [5:0] s;

    rst = 1'b0; en = 1'b0; load = 1'b0; seed_in = 6'd0;
    model_reset();
    #25;
    check_all("reset");
    chk("reset_cnt", 32'(u_gal.cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First steps against literal sequences for both forms.
    step("s1", 1'b1, 1'b0, 6'd0);
    chk("gal_seq1", 32'(q_g), 32'h1F);
    chk("fib_seq1", 32'(q_f), 32'h3E);
    step("s2", 1'b1, 1'b0, 6'd0);
    chk("gal_seq2", 32'(q_g), 32'h3E);
    chk("fib_seq2", 32'(q_f), 32'h3D);

    // Complete the full period of 63 steps.
    foreach (seen[i]) seen[i] = 1'b0;
    seen[q_g] = 1'b1;
    seen[6'h1F] = 1'b1;
    pulses = 0;
    for (int i = 3; i <= 63; i++) begin
      step("period", 1'b1, 1'b0, 6'd0);
      seen[q_g] = 1'b1;
      if (done_g) pulses++;
    end
    distinct = 0;
    for (int i = 1; i < 64; i++) if (seen[i]) distinct++;
    chk("period_distinct", 32'(distinct), 32'd63);
    chk("period_zero_seen", 32'(seen[0]), 32'd0);
    chk("period_pulses", 32'(pulses), 32'd1);
    chk("period_len_gal", 32'(len_g), 32'd63);
    chk("period_len_fib", 32'(len_f), 32'd63);
    chk("period_back_q", 32'(q_g), 32'h3F);
    step("after_period", 1'b1, 1'b0, 6'd0);

    // Zero seed rejected, then load wins over enable.
    step("load_zero", 1'b0, 1'b1, 6'd0);
    chk("load_zero_q", 32'(q_g), 32'h3F);
    chk("load_zero_err", 32'(err_g), 32'd1);
    step("load_seed", 1'b1, 1'b1, 6'b000101);
    chk("load_seed_q", 32'(q_f), 32'h05);
    chk("load_len_kept", 32'(len_g), 32'd63);
    chk("load_err_clear", 32'(err_g), 32'd0);

    // Enable pattern 1,0,0,1: holds must not count toward the period.
    steps = 0;
    for (int i = 0; steps < 63 && i < 200; i++) begin
      e = (i % 4 == 0) || (i % 4 == 3);
      if (e) steps++;
      step("en_toggle", e, 1'b0, 6'd0);
    end
    chk("toggle_len", 32'(len_f), 32'd63);
    chk("toggle_q", 32'(q_g), 32'h05);

    // Randomised mix of steps, holds and loads.
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(9, 0) < 7);
      l = ($urandom_range(19, 0) == 0);
      s = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
      step("rand", e, l, s);
    end

    // Asynchronous reset in the middle of a cycle.
    en = 1'b1;
    @(posedge clk);
    model_update(1'b1, 1'b0, 6'd0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    chk("mid_rst_cnt", 32'(u_fib.cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1'b1, 1'b0, 6'd0);

    // Forced all-zero state recovers to the seed on the next enabled edge.
    force u_gal.state_q = 6'd0;
    force u_fib.state_q = 6'd0;
    mq[0] = 6'd0; mq[1] = 6'd0;
    en = 1'b1; load = 1'b0;
    @(posedge clk);
    #1;
    release u_gal.state_q;
    release u_fib.state_q;
    model_update(1'b1, 1'b0, 6'd0);
    #1;
    check_all("recover");
    chk("recover_q", 32'(q_g), 32'h3F);
    chk("recover_err", 32'(err_f), 32'd1);
    @(negedge clk);
    step("post_recover", 1'b1, 1'b0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
